nibble_serial_add_ctrl: RTL

NIBBLE_SERIAL_ADD_CTRL -- requirements
Module: nibble_serial_add_ctrl

---
 rtl/nibble_serial_add_ctrl.sv | 133 +++++++++++++
 1 files changed

// File: rtl/nibble_serial_add_ctrl.sv
// Serial W-bit adder reusing one 4-bit slice, one nibble per clock; SUB_EN adds a - b mode.
// Latency: done pulses in the cycle after the NIBBLES-th edge following start acceptance.
// Backpressure: start is ignored while busy; start held across done chains with zero gap.

module nibble_rca4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);
  logic [4:0] c;

  assign c[0] = ci;
  for (genvar i = 0; i < 4; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end
  assign co = c[4];
endmodule

module nibble_serial_add_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [4*NIBBLES-1:0]   a,
  input  logic [4*NIBBLES-1:0]   b,
  input  logic                   cin,
  input  logic                   op,
  output logic                   busy,
  output logic                   done,
  output logic [4*NIBBLES-1:0]   sum,
  output logic                   cout
);
  localparam int W  = 4 * NIBBLES;
  localparam int IW = $clog2(NIBBLES);
  localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t          state, state_nxt;
  logic [W-1:0]    a_reg, b_reg, work, work_nxt;
  logic [W-1:0]    b_eff;
  logic            c_eff;
  logic [IW-1:0]   idx;
  logic            cr;
  logic            accept, last;
  logic [3:0]      sl_a, sl_b, sl_s;
  logic            sl_co;

`ifdef SUB_EN
  // Subtract as a + ~b + 1; the inversion is folded in before the operand register.
  assign b_eff = op ? ~b : b;
  assign c_eff = op | cin;
`else
  logic unused_op;
  assign unused_op = op;
  assign b_eff     = b;
  assign c_eff     = cin;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    last      = 1'b0;
    case (state)
      IDLE: if (start) begin
        accept    = 1'b1;
        state_nxt = RUN;
      end
      RUN: if (idx == LAST) begin
        last      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Shifts rather than indexed part-selects keep the nibble mux width-clean for any NIBBLES.
  assign sl_a = 4'(a_reg >> {idx, 2'b00});
  assign sl_b = 4'(b_reg >> {idx, 2'b00});

  nibble_rca4 u_slice (
    .a  (sl_a),
    .b  (sl_b),
    .ci (cr),
    .s  (sl_s),
    .co (sl_co)
  );

  always_comb begin
    work_nxt = (work & ~(W'(4'hF) << {idx, 2'b00})) | (W'(sl_s) << {idx, 2'b00});
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg <= '0;
      b_reg <= '0;
      work  <= '0;
      idx   <= '0;
      cr    <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      done <= last;
      if (accept) begin
        a_reg <= a;
        b_reg <= b_eff;
        cr    <= c_eff;
        work  <= '0;
        idx   <= '0;
      end else if (state == RUN) begin
        work <= work_nxt;
        cr   <= sl_co;
        idx  <= last ? '0 : idx + 1'b1;
      end
      if (last) begin
        sum  <= work_nxt;
        cout <= sl_co;
      end
    end
  end

  assign busy = (state == RUN);
endmodule
